// File: rtl/div_prog.sv
// ---------------------------------------------------------------------------
// div_prog -- programmable clock divider with glitch-free reload
//
// Divides clk by a runtime-programmable integer N (2..2^W-1). A new divisor
// is first parked in a pending register. It only takes over at the end of the
// current output period, so no period is ever shortened or stretched.
//
// Parameters
//   W            width of the divisor and of the period counter
//   DIV_DEFAULT  divisor in force after reset (2..2^W-1)
//
// Ports
//   clk       system clock; all state updates on its rising edge
//             (plus one falling-edge register in the 50% odd-duty build)
//   rst       asynchronous, active-high reset
//   div_val   requested divisor N
//   div_load  one-cycle strobe qualifying div_val
//   div_err   one-cycle pulse when a load is rejected (div_val < 2)
//   pend      a divisor has been accepted but is not yet active
//   clk_out   divided clock
//   tick      one-clk pulse in the first cycle of every output period
//
// Build option
//   ODD_DUTY50_EN  when defined, odd divisors produce a 50% duty clk_out by
//                  ANDing the rising-edge phase with a copy of itself
//                  delayed by half a clk period on the falling edge. When
//                  undefined, no falling-edge logic exists, and odd N gives
//                  floor(N/2) cycles high and ceil(N/2) cycles low.
// ---------------------------------------------------------------------------
module div_prog #(
    parameter int W           = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] div_val,
    input  logic         div_load,
    output logic         div_err,
    output logic         pend,
    output logic         clk_out,
    output logic         tick
);

    localparam logic [W-1:0] DivReset = W'(DIV_DEFAULT);
    localparam logic [W-1:0] DivMin   = W'(2);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] pendVal_q, pendVal_d;
    logic         pend_q, pend_d;
    logic         run_q;
    logic         pos_q, pos_d;
    logic         tick_q, tick_d;
    logic         err_q, err_d;

    logic         loadOk;
    logic         wrap;
    logic [W:0]   hiLimit;

    // Next-state logic. run_q is low only until the first edge after reset.
    // That edge restarts the period at cnt=0 without advancing the counter.
    // The divisor only changes on the wrap edge, so the period in progress
    // always completes with the divisor it started with. A load that lands on
    // the wrap edge is parked for the following wrap. The wrap itself still
    // transfers whatever was pending before that edge.
    always_comb begin
        loadOk    = div_load && (div_val >= DivMin);
        wrap      = run_q && (cnt_q == n_q - W'(1));
        n_d       = n_q;
        pendVal_d = pendVal_q;
        pend_d    = pend_q;
        if (wrap && pend_q) begin
            n_d    = pendVal_q;
            pend_d = 1'b0;
        end
        if (loadOk) begin
            pendVal_d = div_val;
            pend_d    = 1'b1;
        end

        if (!run_q || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end

        // The high-phase limit is computed one bit wider, so N = 2^W-1
        // cannot overflow when rounding up.
`ifdef ODD_DUTY50_EN
        hiLimit = ({1'b0, n_d} + (W+1)'(1)) >> 1;
`else
        hiLimit = {1'b0, n_d} >> 1;
`endif
        // Outputs are decoded from the next count and registered alongside
        // it, so tick and clk_out line up exactly with cnt_q.
        pos_d  = ({1'b0, cnt_d} < hiLimit);
        tick_d = (cnt_d == '0);
        err_d  = div_load && !loadOk;
    end

    // Main rising-edge state. Reset discards any pending divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            n_q       <= DivReset;
            pendVal_q <= DivReset;
            pend_q    <= 1'b0;
            run_q     <= 1'b0;
            pos_q     <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            pendVal_q <= pendVal_d;
            pend_q    <= pend_d;
            run_q     <= 1'b1;
            pos_q     <= pos_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

`ifdef ODD_DUTY50_EN
    logic [W-1:0] nextN;
    logic         neg_q;
    logic         oddSel_q;

    assign nextN = pend_q ? pendVal_q : n_q;

    // Falling-edge copy of pos_q, used to trim half a cycle off odd periods.
    // The odd/even select is refreshed on the falling edge of the last cycle
    // of a period. At that point pos_q and neg_q are both low, so the select
    // changes while the output is held at 0 and can never glitch. Loads that
    // land on the wrap edge do not affect the upcoming period, so nextN is
    // already final here.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_q    <= 1'b0;
            oddSel_q <= DivReset[0];
        end else begin
            neg_q <= pos_q;
            if (wrap) begin
                oddSel_q <= nextN[0];
            end
        end
    end

    assign clk_out = oddSel_q ? (pos_q & neg_q) : pos_q;
`else
    assign clk_out = pos_q;
`endif

    assign tick    = tick_q;
    assign pend    = pend_q;
    assign div_err = err_q;

endmodule

// File: tb/tb_div_prog.sv
// ---------------------------------------------------------------------------
// tb_div_prog -- scoreboard testbench for div_prog
//
// The stimulus process drives directed loads and pushes the divisor expected
// for each upcoming output period into expQ. The monitor process watches
// tick. At the end of each period it pops the expected divisor and compares
// the measured period length and the clk_out high time. High time is counted
// in half clk cycles, so the 50% odd-duty build can be checked as well.
// ---------------------------------------------------------------------------
module tb_div_prog;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] divVal = '0;
    logic         divLoad = 1'b0;
    logic         divErr;
    logic         pend;
    logic         clkOut;
    logic         tick;

    int passCount  = 0;
    int checkCount = 0;
    int errPulses  = 0;
    int expQ[$];

    div_prog #(
        .W(W),
        .DIV_DEFAULT(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .div_val (divVal),
        .div_load(divLoad),
        .div_err (divErr),
        .pend    (pend),
        .clk_out (clkOut),
        .tick    (tick)
    );

    // 20 ns system clock
    always #10 clk = ~clk;

    // Expected clk_out high time, in half clk cycles, for divisor n
    function automatic int expHigh(input int n);
`ifdef ODD_DUTY50_EN
        return n;
`else
        return 2 * (n / 2);
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int val, input bit load);
        divVal  = W'(val);
        divLoad = load;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Advance to the first cycle of the next period (tick high), bounded
    task automatic waitTick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            stepCycle();
            if (tick) seen = 1'b1;
        end
        if (!seen) checkOutput("tick timeout", 0, 1);
    endtask

    // Monitor: measures each completed period and checks it against the queue
    initial begin
        int len;
        int hh;
        int expN;
        len = 0;
        hh  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                len = 0;
                hh  = 0;
            end else begin
                if (divErr) errPulses++;
                if (tick) begin
                    if (len > 0) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected period", len, 0);
                        end else begin
                            expN = expQ.pop_front();
                            checkOutput("period length", len, expN);
                            checkOutput("high half-cycles", hh, expHigh(expN));
                        end
                    end
                    len = 0;
                    hh  = 0;
                end
                len++;
                hh += int'(clkOut);
            end
            @(negedge clk);
            #1;
            if (rst) begin
                len = 0;
                hh  = 0;
            end else begin
                hh += int'(clkOut);
            end
        end
    end

    // Stimulus
    initial begin
        applyStimulus(0, 1'b0);
        rst = 1'b1;
        expQ.push_back(4);
        expQ.push_back(4);
        expQ.push_back(4);

        #50;
        checkOutput("reset clk_out", int'(clkOut), 0);
        checkOutput("reset tick", int'(tick), 0);
        checkOutput("reset pend", int'(pend), 0);
        checkOutput("reset div_err", int'(divErr), 0);

        #50;
        rst = 1'b0;
        stepCycle();
        checkOutput("release tick", int'(tick), 1);
        checkOutput("release clk_out", int'(clkOut), 1);
        checkOutput("release pend", int'(pend), 0);

        // P2: two illegal loads, divisor stays 4
        waitTick();
        stepCycle();
        applyStimulus(1, 1'b1);
        stepCycle();
        checkOutput("div_err val1", int'(divErr), 1);
        applyStimulus(0, 1'b1);
        stepCycle();
        checkOutput("div_err val0", int'(divErr), 1);
        checkOutput("pend after illegal", int'(pend), 0);
        applyStimulus(0, 1'b0);
        stepCycle();
        checkOutput("tick still div4", int'(tick), 1);
        checkOutput("div_err cleared", int'(divErr), 0);

        // P3: reload 6 mid-period, applied from P4
        stepCycle();
        applyStimulus(6, 1'b1);
        expQ.push_back(6);
        expQ.push_back(6);
        stepCycle();
        applyStimulus(0, 1'b0);
        checkOutput("pend after load6", int'(pend), 1);
        waitTick();
        checkOutput("pend cleared at wrap", int'(pend), 0);

        // P5: load odd divisor 5, applied from P6
        waitTick();
        stepCycle();
        applyStimulus(5, 1'b1);
        expQ.push_back(5);
        expQ.push_back(5);
        stepCycle();
        applyStimulus(0, 1'b0);
        waitTick();
        waitTick();

        // P7: back-to-back loads 8 then 3, only 3 is applied
        stepCycle();
        applyStimulus(8, 1'b1);
        stepCycle();
        applyStimulus(3, 1'b1);
        expQ.push_back(3);
        expQ.push_back(3);
        stepCycle();
        applyStimulus(0, 1'b0);
        checkOutput("pend after 8,3", int'(pend), 1);
        waitTick();
        waitTick();

        // P9 (N=3): pending 4, then a load of 6 on the wrap edge
        stepCycle();
        applyStimulus(4, 1'b1);
        expQ.push_back(4);
        expQ.push_back(6);
        stepCycle();
        applyStimulus(6, 1'b1);
        stepCycle();
        applyStimulus(0, 1'b0);
        checkOutput("tick after wrap load", int'(tick), 1);
        checkOutput("pend kept after wrap load", int'(pend), 1);
        waitTick();
        checkOutput("pend cleared second wrap", int'(pend), 0);

        // P11 (N=6): pending load, then reset at cnt=2
        stepCycle();
        applyStimulus(2, 1'b1);
        stepCycle();
        applyStimulus(0, 1'b0);
        checkOutput("pend before reset", int'(pend), 1);
        checkOutput("clk_out before reset", int'(clkOut), 1);
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midrun reset clk_out", int'(clkOut), 0);
        checkOutput("midrun reset pend", int'(pend), 0);
        checkOutput("midrun reset tick", int'(tick), 0);
        checkOutput("midrun reset div_err", int'(divErr), 0);

        repeat (3) @(negedge clk);
        expQ.push_back(4);
        expQ.push_back(4);
        rst = 1'b0;
        stepCycle();
        checkOutput("re-release tick", int'(tick), 1);
        checkOutput("re-release clk_out", int'(clkOut), 1);
        waitTick();
        waitTick();
        stepCycle();
        checkOutput("scoreboard drained", expQ.size(), 0);
        checkOutput("div_err pulse count", errPulses, 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
